bitserial_adder_46: RTL and testbench
=====================================

// Module: bitserial_adder_46
// PURPOSE
//   Bit-serial WIDTH-bit adder built around a single full-adder cell and a carry flip-flop.
//   Operands are loaded in parallel and processed LSB-first, one bit per clock.
//   The carry from each bit is registered and fed into the next bit.
//   Sits upstream of the result/display logic in the Fulladder_4 design and trades latency for area.
// PARAMETERS
//   WIDTH   4   operand and sum width in bits; must be >= 1
// PORTS
//   clk      in   1      single clock; all state updates on its rising edge
//   rst      in   1      reset, synchronous and active-high
//   start    in   1      request; sampled only when not busy
//   a_in     in   WIDTH  operand A; latched when start is accepted
//   b_in     in   WIDTH  operand B; latched when start is accepted
//   cin      in   1      carry-in; latched when start is accepted
//   busy     out  1      high while bits are being shifted
//   done     out  1      one-cycle pulse; sum and cout are valid from this cycle on
//   sum      out  WIDTH  result of the last completed operation
//   cout     out  1      carry-out of the last completed operation
// BEHAVIOUR
//   - Reset (rst=1 at a clk edge): state=IDLE; busy=0, done=0, sum=0, cout=0.
//     Operand, carry and count registers are cleared.
//     Reset has priority over every other input and aborts an operation in flight.
//     No done pulse is issued for the aborted operation, and sum/cout return to 0.
//   - States: IDLE, SHIFT, DONE.
//     - IDLE or DONE, start=1: latch a_in, b_in, cin into a_r, b_r, c_r; clear cnt; go to SHIFT.
//     - IDLE, start=0: stay in IDLE.
//     - DONE, start=0: go to IDLE.
//     - SHIFT: each edge computes s = a_r[0]^b_r[0]^c_r and c_r <= maj(a_r[0], b_r[0], c_r).
//       s is shifted into the MSB of res_r, and a_r, b_r shift right by one bit.
//       cnt increments on each SHIFT edge; the edge with cnt==WIDTH-1 moves the block to DONE.
//     - DONE lasts exactly one cycle.
//   - busy = (state==SHIFT). done = (state==DONE).
//   - sum/cout are loaded from the final res_r/c_r only on the edge entering DONE.
//     They hold that value through later operations until the next completion.
//   - Latency: start sampled at edge k gives done=1 in the cycle after edge k+WIDTH.
//     Back-to-back: start held high during DONE begins the next operation with no idle cycle,
//     giving a throughput of 1 result per WIDTH+1 cycles.
//   - start while busy is ignored: no effect on operands, count or outputs.
//   - Arithmetic: {cout,sum} == a_in + b_in + cin, computed modulo 2^(WIDTH+1); no overflow flag.
//   - WIDTH=1: SHIFT lasts a single cycle. The count register is max(1,$clog2(WIDTH)) bits wide.
// CONFIGURATION
//   BITSERIAL_SUB_EN defined:
//     - Adds input port sub (1 bit), latched together with the operands.
//     - With sub=1 the block computes a_in + ~b_in + 1; cin is ignored and the carry flop is preloaded with 1.
//     - cout=1 means no borrow (a_in >= b_in, unsigned).
//     - sub=0 behaves exactly as the add path.
//   BITSERIAL_SUB_EN undefined: no sub port; add-only behaviour as described above.
// TESTING (WIDTH=4)
//   1. a=5, b=3, cin=0, start for 1 cycle -> busy high for 4 cycles, then done pulse; sum=8, cout=0.
//   2. a=F, b=1, cin=0 -> sum=0, cout=1. a=F, b=F, cin=1 -> sum=F, cout=1.
//   3. All 512 {a,b,cin} combinations, start held high continuously.
//      -> each done shows {cout,sum}==a+b+cin; done is 5 cycles apart.
//   4. start a=5, b=3; pulse start with a=F, b=F during SHIFT -> ignored; result sum=8, cout=0.
//   5. rst=1 on the 2nd SHIFT cycle -> next cycle busy=0, done=0, sum=0, cout=0.
//      No done pulse follows; a fresh start then completes normally.
//   6. BITSERIAL_SUB_EN: sub=1, a=5, b=3 -> sum=2, cout=1. sub=1, a=3, b=5 -> sum=E, cout=0.

Source files
------------

// File: rtl/bitserial_adder_46.sv
// rtl/bitserial_adder_46.sv - bit-serial LSB-first adder, one full-adder cell plus carry flop
// Optional subtract mode (port sub) is compiled in when BITSERIAL_SUB_EN is defined.
module bitserial_adder_46 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef BITSERIAL_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_r, b_r, res_r;
  logic             c_r;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;

  logic             load;
  logic             shift_en;
  logic             last_bit;
  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  // The single full-adder cell shared by every bit position.
  always_comb begin
    s_bit    = a_r[0] ^ b_r[0] ^ c_r;
    c_next   = (a_r[0] & b_r[0]) | (a_r[0] & c_r) | (b_r[0] & c_r);
    res_next = res_r >> 1;
    res_next[WIDTH-1] = s_bit;
  end

`ifdef BITSERIAL_SUB_EN
  // Subtraction is a + ~b + 1: invert b and preload the carry flop.
  always_comb begin
    b_load = sub ? ~b_in : b_in;
    c_load = sub ? 1'b1 : cin;
  end
`else
  always_comb begin
    b_load = b_in;
    c_load = cin;
  end
`endif

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    shift_en = 1'b0;
    last_bit = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift_en = 1'b1;
        if (cnt == LAST) begin
          last_bit = 1'b1;
          state_n  = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          load    = 1'b1;
          state_n = S_SHIFT;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      a_r    <= '0;
      b_r    <= '0;
      c_r    <= 1'b0;
      res_r  <= '0;
      cnt    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else begin
      state <= state_n;
      if (load) begin
        a_r   <= a_in;
        b_r   <= b_load;
        c_r   <= c_load;
        res_r <= '0;
        cnt   <= '0;
      end else if (shift_en) begin
        a_r   <= a_r >> 1;
        b_r   <= b_r >> 1;
        c_r   <= c_next;
        res_r <= res_next;
        cnt   <= cnt + 1'b1;
      end
      // Results only move on completion so they persist across later operations.
      if (last_bit) begin
        sum_r  <= res_next;
        cout_r <= c_next;
      end
    end
  end

  assign busy = (state == S_SHIFT);
  assign done = (state == S_DONE);
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_bitserial_adder_46.sv
// tb/tb_bitserial_adder_46.sv - directed self-checking bench for bitserial_adder_46 (WIDTH=4)
module tb_bitserial_adder_46;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a_in, b_in;
  logic       cin;
  logic       busy, done, cout;
  logic [3:0] sum;
`ifdef BITSERIAL_SUB_EN
  logic       sub = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  bitserial_adder_46 #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
`ifdef BITSERIAL_SUB_EN
    .sub   (sub),
`endif
    .a_in  (a_in),
    .b_in  (b_in),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation and wait (bounded) for done.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic c,
                        output int lat, output int busy_cnt);
    a_in = a; b_in = b; cin = c; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a_in = 4'h0; b_in = 4'h0; cin = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, cout, sum} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b cout=%b sum=%h, want all 0", busy, done, cout, sum);
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    run_op(4'h5, 4'h3, 1'b0, lat, bc);
    checks++;
    if (done !== 1'b1 || lat != 5) begin
      errors++;
      $display("FAIL basic_latency: got done=%b after %0d cycles, want done=1 after 5", done, lat);
    end
    checks++;
    if (bc != 4) begin
      errors++;
      $display("FAIL basic_busy: got %0d busy cycles, want 4", bc);
    end
    checks++;
    if ({cout, sum} !== 5'h08) begin
      errors++;
      $display("FAIL basic_sum: got cout=%b sum=%h, want cout=0 sum=8", cout, sum);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || {cout, sum} !== 5'h08) begin
      errors++;
      $display("FAIL basic_hold: got done=%b busy=%b cout=%b sum=%h, want 0 0 0 8", done, busy, cout, sum);
    end
  endtask

  task automatic test_carry();
    int lat, bc;
    run_op(4'hF, 4'h1, 1'b0, lat, bc);
    checks++;
    if (done !== 1'b1 || {cout, sum} !== 5'h10) begin
      errors++;
      $display("FAIL carry_f_1: got done=%b cout=%b sum=%h, want 1 1 0", done, cout, sum);
    end
    tick();
    run_op(4'hF, 4'hF, 1'b1, lat, bc);
    checks++;
    if (done !== 1'b1 || {cout, sum} !== 5'h1F) begin
      errors++;
      $display("FAIL carry_f_f_1: got done=%b cout=%b sum=%h, want 1 1 f", done, cout, sum);
    end
    tick();
  endtask

  // All 512 {a,b,cin} combinations with start held high.
  task automatic test_back_to_back();
    int gap;
    logic [8:0] v, nv;
    logic [4:0] exp;
    v = 9'd0;
    {a_in, b_in, cin} = v;
    start = 1'b1;
    for (int i = 0; i < 512; i++) begin
      gap = 0;
      do begin
        tick();
        gap++;
      end while (!done && gap < 12);
      exp = {1'b0, v[8:5]} + {1'b0, v[4:1]} + {4'b0, v[0]};
      checks++;
      if (done !== 1'b1 || {cout, sum} !== exp) begin
        errors++;
        $display("FAIL b2b_sum[%0d]: got done=%b cout_sum=%h, want done=1 cout_sum=%h", i, done, {cout, sum}, exp);
      end
      checks++;
      if (gap != 5) begin
        errors++;
        $display("FAIL b2b_gap[%0d]: got %0d cycles between done, want 5", i, gap);
      end
      nv = v + 9'd1;
      v = nv;
      {a_in, b_in, cin} = v;
      if (i == 511) start = 1'b0;
    end
    tick();
  endtask

  task automatic test_busy_ignore();
    int n;
    a_in = 4'h5; b_in = 4'h3; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a_in = 4'hF; b_in = 4'hF; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n = 3;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (done !== 1'b1 || n != 5 || {cout, sum} !== 5'h08) begin
      errors++;
      $display("FAIL busy_ignore: got done=%b at %0d cout=%b sum=%h, want done=1 at 5 cout=0 sum=8", done, n, cout, sum);
    end
    tick();
  endtask

  task automatic test_abort();
    int seen, lat, bc;
    a_in = 4'h5; b_in = 4'h3; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, cout, sum} !== 7'b0) begin
      errors++;
      $display("FAIL abort_clear: got busy=%b done=%b cout=%b sum=%h, want all 0", busy, done, cout, sum);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_quiet: got %0d busy/done cycles after abort, want 0", seen);
    end
    run_op(4'h2, 4'h7, 1'b1, lat, bc);
    checks++;
    if (done !== 1'b1 || lat != 5 || {cout, sum} !== 5'h0A) begin
      errors++;
      $display("FAIL abort_restart: got done=%b lat=%0d cout=%b sum=%h, want 1 5 0 a", done, lat, cout, sum);
    end
    tick();
  endtask

`ifdef BITSERIAL_SUB_EN
  task automatic test_sub();
    int lat, bc;
    sub = 1'b1;
    run_op(4'h5, 4'h3, 1'b0, lat, bc);
    checks++;
    if (done !== 1'b1 || {cout, sum} !== 5'h12) begin
      errors++;
      $display("FAIL sub_5_3: got done=%b cout=%b sum=%h, want 1 1 2", done, cout, sum);
    end
    tick();
    run_op(4'h3, 4'h5, 1'b1, lat, bc);
    checks++;
    if (done !== 1'b1 || {cout, sum} !== 5'h0E) begin
      errors++;
      $display("FAIL sub_3_5: got done=%b cout=%b sum=%h, want 1 0 e", done, cout, sum);
    end
    tick();
    sub = 1'b0;
    run_op(4'h5, 4'h3, 1'b1, lat, bc);
    checks++;
    if (done !== 1'b1 || {cout, sum} !== 5'h09) begin
      errors++;
      $display("FAIL sub_off: got done=%b cout=%b sum=%h, want 1 0 9", done, cout, sum);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_busy_ignore();
    test_abort();
`ifdef BITSERIAL_SUB_EN
    test_sub();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
